tdma_slot_sched: RTL and testbench

Time-division channel scheduler that sequences one node's radio transceiver (txrx) on the shared antenna medium between SoCs. It divides time into frames of N_SLOTS equal slots. In each slot it decides whether the radio sleeps, transmits (own slot with a pending packet) or listens (slot enabled in the receive mask), and drives the radio power, TX-enable and RX-enable with wake-up and guard intervals. It sits between the CPU-visible configuration registers and the txrx block, one instance per SoC.

---
 rtl/tdma_slot_sched_if.sv | 12 +
 rtl/tdma_slot_sched.sv | 101 ++++++++++
 tb/tb_tdma_slot_sched.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/tdma_slot_sched_if.sv
// tdma_slot_sched_if: radio-side handshake between the slot scheduler and txrx
interface tdma_slot_sched_if;
    logic tx_req;
    logic tx_busy;
    logic radio_on;
    logic tx_en;
    logic rx_en;
    logic tx_ack;
    logic tx_overrun;
    modport master (input tx_req, tx_busy, output radio_on, tx_en, rx_en, tx_ack, tx_overrun);
    modport slave (output tx_req, tx_busy, input radio_on, tx_en, rx_en, tx_ack, tx_overrun);
endinterface

// File: rtl/tdma_slot_sched.sv
// tdma_slot_sched: TDMA frame/slot sequencer for the radio; TDMA_OVERRUN_DET_EN enables tx_overrun detection
module tdma_slot_sched #(
    parameter int N_SLOTS = 8,
    parameter int SLOT_W = 16,
    parameter int ID_W = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic [ID_W-1:0] node_id,
    input  logic [SLOT_W-1:0] slot_len,
    input  logic [SLOT_W-1:0] wakeup_len,
    input  logic [SLOT_W-1:0] guard_len,
    input  logic [N_SLOTS-1:0] rx_mask,
    output logic [ID_W-1:0] slot_idx,
    output logic frame_start,
    output logic cfg_err,
    tdma_slot_sched_if.master radio
);
    localparam logic [2:0] IDLE = 3'd0, SLEEP = 3'd1, WAKE = 3'd2, ACTIVE = 3'd3, GUARD = 3'd4;
    localparam logic [1:0] NONE = 2'd0, TX = 2'd1, RX = 2'd2;

    logic [2:0] state_q, state_d;
    logic [1:0] role_q, role_d;
    logic [SLOT_W-1:0] cnt_q, cnt_d, slen_q, slen_d, wlen_q, wlen_d, glen_q, glen_d;
    logic [ID_W-1:0] slot_q, slot_d, node_q, node_d;
    logic cfg_err_q, cfg_err_d, frame_q, frame_d, ack_q, ack_d;
    logic enter, frame;

    // slot/frame boundaries, frame-latched config, slot-latched role, next state
    always_comb begin
        enter = state_q == IDLE || cnt_q == slen_q - 1'b1;
        cnt_d = enter ? '0 : cnt_q + 1'b1;
        slot_d = state_q == IDLE ? '0 : enter ? slot_q + 1'b1 : slot_q;
        frame = enter && slot_d == '0;
        slen_d = frame ? slot_len : slen_q;
        wlen_d = frame ? wakeup_len : wlen_q;
        glen_d = frame ? guard_len : glen_q;
        node_d = frame ? node_id : node_q;
        cfg_err_d = frame ? ({1'b0, wakeup_len} + {1'b0, guard_len} >= {1'b0, slot_len} || slot_len < SLOT_W'(4)) : cfg_err_q;
        role_d = !enter ? role_q : (slot_d == node_d && radio.tx_req) ? TX : rx_mask[slot_d] ? RX : NONE;
        state_d = (cfg_err_d || role_d == NONE) ? SLEEP : cnt_d < wlen_d ? WAKE : cnt_d < slen_d - glen_d ? ACTIVE : GUARD;
        frame_d = frame;
        ack_d = state_d == ACTIVE && role_d == TX && (state_q != ACTIVE || enter);
    end

    // disabled or reset parks everything at slot 0 with outputs low
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            state_q <= IDLE;
            role_q <= NONE;
            cnt_q <= '0;
            slot_q <= '0;
            slen_q <= '0;
            wlen_q <= '0;
            glen_q <= '0;
            node_q <= '0;
            cfg_err_q <= 1'b0;
            frame_q <= 1'b0;
            ack_q <= 1'b0;
        end else begin
            state_q <= state_d;
            role_q <= role_d;
            cnt_q <= cnt_d;
            slot_q <= slot_d;
            slen_q <= slen_d;
            wlen_q <= wlen_d;
            glen_q <= glen_d;
            node_q <= node_d;
            cfg_err_q <= cfg_err_d;
            frame_q <= frame_d;
            ack_q <= ack_d;
        end
    end

    assign radio.radio_on = state_q == WAKE || state_q == ACTIVE || state_q == GUARD;
    assign radio.tx_en = state_q == ACTIVE && role_q == TX;
    assign radio.rx_en = state_q == ACTIVE && role_q == RX;
    assign radio.tx_ack = ack_q;
    assign slot_idx = slot_q;
    assign frame_start = frame_q;
    assign cfg_err = cfg_err_q;

`ifdef TDMA_OVERRUN_DET_EN
    logic gfirst_q;

    // marks the first GUARD cycle of each slot
    always_ff @(posedge clk) begin
        if (reset || !en)
            gfirst_q <= 1'b0;
        else
            gfirst_q <= state_d == GUARD && (state_q != GUARD || enter);
    end

    assign radio.tx_overrun = gfirst_q && role_q == TX && radio.tx_busy;
`else
    logic unused_busy;
    assign unused_busy = radio.tx_busy;
    assign radio.tx_overrun = 1'b0;
`endif
endmodule

// File: tb/tb_tdma_slot_sched.sv
// tb_tdma_slot_sched: scoreboard bench for tdma_slot_sched (N_SLOTS=4, slot_len=20)
module tb_tdma_slot_sched;
    localparam int NS = 4;
    localparam int SW = 16;
    localparam int IW = 2;
    localparam int SL = 20;

    typedef struct packed {
        logic r, t, x, a, f, e, o;
        logic [IW-1:0] s;
    } exp_t;

    logic clk = 1'b0;
    logic reset, en;
    logic [IW-1:0] node_id, slot_idx;
    logic [SW-1:0] slot_len, wakeup_len, guard_len;
    logic [NS-1:0] rx_mask;
    logic frame_start, cfg_err;
    int n_tests = 0;
    int n_fail = 0;
    int t = -1;
    int wl = 0, gl = 0, nl = 0, role = 0;
    bit err = 0;
    exp_t sb[$];

    tdma_slot_sched_if rif();

    tdma_slot_sched #(.N_SLOTS(NS), .SLOT_W(SW), .ID_W(IW)) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .node_id(node_id),
        .slot_len(slot_len),
        .wakeup_len(wakeup_len),
        .guard_len(guard_len),
        .rx_mask(rx_mask),
        .slot_idx(slot_idx),
        .frame_start(frame_start),
        .cfg_err(cfg_err),
        .radio(rif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (model t=%0d, time %0t)", tag, got, exp, t, $time);
        end
    endtask

    // predict the cycle following the next edge, push it, then compare after the edge
    task automatic step();
        exp_t e, g;
        int cnt, slot;
        e = '0;
        if (reset || !en) begin
            t = -1;
            err = 0;
        end else begin
            t++;
            cnt = t % SL;
            slot = (t / SL) % NS;
            if (cnt == 0 && slot == 0) begin
                wl = int'(wakeup_len);
                gl = int'(guard_len);
                nl = int'(node_id);
                err = wl + gl >= SL;
            end
            if (cnt == 0)
                role = (slot == nl && rif.tx_req) ? 1 : rx_mask[slot] ? 2 : 0;
            e.s = IW'(slot);
            e.f = cnt == 0 && slot == 0;
            e.e = err;
            e.r = !err && role != 0;
            e.t = e.r && role == 1 && cnt >= wl && cnt < SL - gl;
            e.x = e.r && role == 2 && cnt >= wl && cnt < SL - gl;
            e.a = e.t && cnt == wl;
`ifdef TDMA_OVERRUN_DET_EN
            e.o = e.r && role == 1 && cnt == SL - gl && rif.tx_busy;
`endif
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        chk("radio_on", 32'(rif.radio_on), 32'(g.r));
        chk("tx_en", 32'(rif.tx_en), 32'(g.t));
        chk("rx_en", 32'(rif.rx_en), 32'(g.x));
        chk("tx_ack", 32'(rif.tx_ack), 32'(g.a));
        chk("frame_start", 32'(frame_start), 32'(g.f));
        chk("cfg_err", 32'(cfg_err), 32'(g.e));
        chk("tx_overrun", 32'(rif.tx_overrun), 32'(g.o));
        chk("slot_idx", 32'(slot_idx), 32'(g.s));
    endtask

    task automatic run_to(input int pos);
        for (int i = 0; i < 200 && (t < 0 || t % (NS * SL) != pos); i++)
            step();
        chk("run_to_reached", 32'(t % (NS * SL)), 32'(pos));
    endtask

    initial begin
        reset = 1'b1;
        en = 1'b1;
        node_id = 2'd1;
        slot_len = SW'(SL);
        wakeup_len = 16'd3;
        guard_len = 16'd2;
        rx_mask = '0;
        rif.tx_req = 1'b1;
        rif.tx_busy = 1'b0;
        repeat (5) step();
        reset = 1'b0;
        repeat (160) step();
        rif.tx_req = 1'b0;
        repeat (80) step();
        rx_mask = 4'b0111;
        rif.tx_req = 1'b1;
        repeat (80) step();
        rx_mask = '0;
        run_to(28);
        en = 1'b0;
        repeat (3) step();
        en = 1'b1;
        repeat (100) step();
        wakeup_len = 16'd10;
        guard_len = 16'd10;
        repeat (200) step();
        wakeup_len = 16'd3;
        guard_len = 16'd2;
        repeat (120) step();
        for (int i = 0; i < 160; i++) begin
            rif.tx_busy = ((t + 1) / SL) % NS == 1 && (t + 1) % SL <= 18;
            step();
        end
        for (int i = 0; i < 240; i++) begin
            rif.tx_busy = 1'($urandom_range(0, 1));
            if (i % 7 == 0) rif.tx_req = 1'($urandom_range(0, 1));
            if (i % 11 == 0) rx_mask = 4'($urandom_range(0, 15));
            step();
        end
        rif.tx_req = 1'b1;
        rx_mask = 4'b1000;
        run_to(30);
        node_id = 2'd2;
        repeat (160) step();
        run_to(50);
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (60) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
